// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instruction memory and
// latches the returned word into the IF/ID pipeline register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [1:0]  J_TYPE_CODE = 2'b01
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic [31:0] instruction,
    output logic [31:0] address_bus,
    output logic [31:0] ifid_instruction,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_p0;
    state_t      state_next;
    logic [31:0] pc_p0;
    logic [31:0] pc_next;
    logic        ifid_load;
    logic        vld_next;
    logic        halted_next;

    logic        word_stop;
    logic        word_jump;
    logic [31:0] pc_seq;
    logic [31:0] pc_jump;

    // Word-align any byte address; the fetch path never sees bits [1:0].
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Jump target: sign-extended 24-bit word offset, scaled to bytes,
    // added modulo 2^32.
    function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                                input logic [31:0] word);
        logic signed [31:0] offset;
        offset = {{6{word[26]}}, word[26:3], 2'b00};
        return pc + offset;
    endfunction

    // Field decode of the word returned for the current PC.
    always_comb begin
        word_stop = instruction[0];
        word_jump = (instruction[2:1] == J_TYPE_CODE);
        pc_seq    = pc_p0 + 32'd4;
        pc_jump   = jump_target(pc_p0, instruction);
    end

    assign address_bus = align_word(pc_p0);

    // Next-state / next-PC selection: redirect > HALT > stall > Stop > jump > sequential.
    always_comb begin
        state_next  = state_p0;
        pc_next     = pc_p0;
        ifid_load   = 1'b0;
        vld_next    = ifid_valid;
        halted_next = halted;
        if (redirect_valid) begin
            pc_next     = align_word(redirect_target);
            vld_next    = 1'b0;
            state_next  = RUN;
            halted_next = 1'b0;
        end else if (state_p0 == HALT) begin
            if (!stall) begin
                vld_next = 1'b0;
            end
        end else if (!stall) begin
            ifid_load = 1'b1;
            vld_next  = 1'b1;
            if (word_stop) begin
                state_next  = HALT;
                halted_next = 1'b1;
            end else if (word_jump) begin
                pc_next = pc_jump;
            end else begin
                pc_next = pc_seq;
            end
        end
    end

    // IF stage: PC and FSM state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_p0    <= align_word(RESET_PC);
            state_p0 <= RUN;
            halted   <= 1'b0;
        end else begin
            pc_p0    <= pc_next;
            state_p0 <= state_next;
            halted   <= halted_next;
        end
    end

    // IF/ID boundary: latch the fetched word with its address and link value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ifid_instruction <= 32'd0;
            ifid_pc          <= 32'd0;
            ifid_pc_plus4    <= 32'd0;
            ifid_valid       <= 1'b0;
        end else begin
            ifid_valid <= vld_next;
            if (ifid_load) begin
                ifid_instruction <= instruction;
                ifid_pc          <= address_bus;
                ifid_pc_plus4    <= pc_seq;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small combinational instruction memory.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instruction;
    logic [31:0] address_bus;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        halted;

    int errors;
    int checks;

    // Encodings: {Function[31:27], Imm[26:3], Type[2:1], Stop[0]}
    localparam logic [31:0] ADDI_A = {5'h02, 24'd5, 2'b00, 1'b0};
    localparam logic [31:0] ADDI_B = {5'h02, 24'd7, 2'b00, 1'b0};
    localparam logic [31:0] ADD_W  = {5'h01, 24'd0, 2'b10, 1'b0};
    localparam logic [31:0] J_M3   = {5'h10, 24'hFFFFFD, 2'b01, 1'b0};
    localparam logic [31:0] J_M12  = {5'h10, 24'hFFFFF4, 2'b01, 1'b0};
    localparam logic [31:0] STOP_W = {5'h1F, 24'd4, 2'b01, 1'b1};

    logic [31:0] imem [64];

    assign instruction = imem[address_bus[7:2]];

    fetch_unit #(.RESET_PC(32'h0000_0000), .J_TYPE_CODE(2'b01)) dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .instruction      (instruction),
        .address_bus      (address_bus),
        .ifid_instruction (ifid_instruction),
        .ifid_pc          (ifid_pc),
        .ifid_pc_plus4    (ifid_pc_plus4),
        .ifid_valid       (ifid_valid),
        .halted           (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk_state(input string tag, input logic [31:0] addr,
                             input logic [31:0] ipc, input logic vld, input logic hlt);
        check({tag, ".addr"},   address_bus, addr);
        check({tag, ".ifpc"},   ifid_pc, ipc);
        check({tag, ".vld"},    {31'd0, ifid_valid}, {31'd0, vld});
        check({tag, ".halted"}, {31'd0, halted}, {31'd0, hlt});
    endtask

    task automatic chk_reset(input string tag);
        check({tag, ".addr"},  address_bus, 32'h0);
        check({tag, ".instr"}, ifid_instruction, 32'h0);
        check({tag, ".ifpc"},  ifid_pc, 32'h0);
        check({tag, ".pc4"},   ifid_pc_plus4, 32'h0);
        check({tag, ".vld"},   {31'd0, ifid_valid}, 32'h0);
        check({tag, ".hlt"},   {31'd0, halted}, 32'h0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        imem[0]  = ADDI_A;   // 0x00
        imem[1]  = ADDI_B;   // 0x04
        imem[2]  = ADD_W;    // 0x08
        imem[3]  = J_M3;     // 0x0C -> 0x00
        imem[4]  = STOP_W;   // 0x10
        imem[5]  = ADDI_B;   // 0x14
        imem[8]  = ADDI_A;   // 0x20
        imem[16] = J_M12;    // 0x40 -> 0x10
        imem[63] = ADDI_A;   // 0xFFFFFFFC aliases here

        reset = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        #2 reset = 1'b1;
        #1;
        chk_reset("rst0");
        @(negedge clock);
        reset = 1'b0;

        // Sequential fetch
        step();
        chk_state("seq1", 32'h4, 32'h0, 1'b1, 1'b0);
        check("seq1.instr", ifid_instruction, ADDI_A);
        check("seq1.pc4", ifid_pc_plus4, 32'h4);
        step();
        chk_state("seq2", 32'h8, 32'h4, 1'b1, 1'b0);
        step();
        chk_state("seq3", 32'hC, 32'h8, 1'b1, 1'b0);
        check("seq3.instr", ifid_instruction, ADD_W);

        // Jump with Immediate=-3 at 0xC
        step();
        chk_state("jmp", 32'h0, 32'hC, 1'b1, 1'b0);
        check("jmp.instr", ifid_instruction, J_M3);
        check("jmp.pc4", ifid_pc_plus4, 32'h10);
        step();
        step();
        chk_state("pre_stall", 32'h8, 32'h4, 1'b1, 1'b0);

        // Stall two cycles at PC=0x8
        stall = 1'b1;
        step();
        chk_state("stall1", 32'h8, 32'h4, 1'b1, 1'b0);
        check("stall1.instr", ifid_instruction, ADDI_B);
        step();
        chk_state("stall2", 32'h8, 32'h4, 1'b1, 1'b0);
        stall = 1'b0;
        step();
        chk_state("resume1", 32'hC, 32'h8, 1'b1, 1'b0);
        step();
        chk_state("resume2", 32'h0, 32'hC, 1'b1, 1'b0);

        // Redirect wins over stall; target low bits cleared
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h41;
        step();
        chk_state("redir", 32'h40, 32'hC, 1'b0, 1'b0);
        stall = 1'b0;
        redirect_valid = 1'b0;

        // Negative jump 0x40 -> 0x10, then Stop
        step();
        chk_state("jneg", 32'h10, 32'h40, 1'b1, 1'b0);
        step();
        chk_state("stop1", 32'h10, 32'h10, 1'b1, 1'b1);
        check("stop1.instr", ifid_instruction, STOP_W);
        step();
        chk_state("stop2", 32'h10, 32'h10, 1'b0, 1'b1);
        step();
        chk_state("stop3", 32'h10, 32'h10, 1'b0, 1'b1);

        // Leave HALT by redirect to 0x20
        redirect_valid = 1'b1;
        redirect_target = 32'h20;
        step();
        chk_state("unhalt", 32'h20, 32'h10, 1'b0, 1'b0);
        redirect_valid = 1'b0;
        step();
        chk_state("run20", 32'h24, 32'h20, 1'b1, 1'b0);
        check("run20.instr", ifid_instruction, ADDI_A);

        // Wrap-around at top of address space
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wrap.addr0", address_bus, 32'hFFFF_FFFC);
        step();
        chk_state("wrap", 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0);
        check("wrap.pc4", ifid_pc_plus4, 32'h0);

        // Halt while stalled keeps the Stop word valid
        redirect_valid = 1'b1;
        redirect_target = 32'h10;
        step();
        redirect_valid = 1'b0;
        step();
        chk_state("hstop", 32'h10, 32'h10, 1'b1, 1'b1);
        stall = 1'b1;
        step();
        chk_state("hstall", 32'h10, 32'h10, 1'b1, 1'b1);
        stall = 1'b0;
        step();
        chk_state("hrel", 32'h10, 32'h10, 1'b0, 1'b1);

        // Run to PC=0x14 then assert reset between edges
        redirect_valid = 1'b1;
        redirect_target = 32'h14;
        step();
        redirect_valid = 1'b0;
        chk_state("at14", 32'h14, 32'h10, 1'b0, 1'b0);
        step();
        chk_state("run14", 32'h18, 32'h14, 1'b1, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk_reset("async");

        // Reset held dominates stall and redirect
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        step();
        chk_reset("rsthold");
        stall = 1'b0;
        redirect_valid = 1'b0;
        reset = 1'b0;

        // First fetch after reset latches the word at RESET_PC
        step();
        chk_state("first", 32'h4, 32'h0, 1'b1, 1'b0);
        check("first.instr", ifid_instruction, ADDI_A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
